relobi_r_other_dec_pipe: RTL

RELOBI_R_OTHER_DEC_PIPE -- requirements
Module: relobi_r_other_dec_pipe

---
 rtl/obi_pkg.sv | 25 ++
 rtl/relobi_pkg.sv | 27 ++
 rtl/relobi_r_other_dec_pipe_pkg.sv | 8 +
 rtl/hsiao_ecc_dec.sv | 55 +++++
 rtl/relobi_r_other_dec_pipe.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/obi_pkg.sv
// OBI bus configuration types.
// Only the fields the relOBI R-channel decode path needs are modelled.
package obi_pkg;

    typedef struct packed {
        logic        UseAtop;
        int unsigned RUserWidth;
        int unsigned RChkWidth;
    } obi_optional_cfg_t;

    typedef struct packed {
        int unsigned       IdWidth;
        obi_optional_cfg_t OptionalCfg;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        IdWidth:     32'd1,
        OptionalCfg: '{
            UseAtop:    1'b0,
            RUserWidth: 32'd0,
            RChkWidth:  32'd0
        }
    };

endpackage

// File: rtl/relobi_pkg.sv
// relOBI width helpers shared by the ECC encode/decode blocks.
// Hsiao check width is the smallest r with 2^(r-1) - r >= k.
package relobi_pkg;

    import obi_pkg::*;

    function automatic int unsigned hsiao_prot_width(int unsigned k);
        int unsigned r;
        r = 32'd2;
        for (int unsigned i = 2; i < 31; i++) begin
            if (((32'd1 << (i - 1)) - i) < k) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned relobi_r_other_width(obi_cfg_t cfg);
        return cfg.IdWidth
             + (cfg.OptionalCfg.UseAtop ? 32'd1 : 32'd0)
             + cfg.OptionalCfg.RUserWidth
             + cfg.OptionalCfg.RChkWidth;
    endfunction

    function automatic int unsigned relobi_r_other_ecc_width(obi_cfg_t cfg);
        return hsiao_prot_width(relobi_r_other_width(cfg));
    endfunction

endpackage

// File: rtl/relobi_r_other_dec_pipe_pkg.sv
// Local constants for the R "other" decode pipe.
// Decoder err vector bit positions.
package relobi_r_other_dec_pipe_pkg;

    localparam int unsigned CorrBit   = 0;
    localparam int unsigned UncorrBit = 1;

endpackage

// File: rtl/hsiao_ecc_dec.sv
// Hsiao SEC-DED decoder; codeword is {check, data}.
// Data columns are odd-weight (>=3) values in ascending order.
module hsiao_ecc_dec
    import relobi_pkg::*;
#(
    parameter  int unsigned DataWidth  = 8,
    parameter  int unsigned ProtWidth  = hsiao_prot_width(DataWidth),
    localparam int unsigned TotalWidth = DataWidth + ProtWidth
) (
    input  logic [TotalWidth-1:0] in_i,
    output logic [DataWidth-1:0]  out_o,
    output logic [1:0]            err_o
);

    typedef logic [DataWidth-1:0][ProtWidth-1:0] col_arr_t;

    function automatic col_arr_t gen_cols();
        col_arr_t    c;
        int unsigned n;
        c = '0;
        n = 0;
        for (int v = 1; v < (1 << ProtWidth); v++) begin
            if (($countones(v) % 2 == 1) && ($countones(v) >= 3)
                && (n < DataWidth)) begin
                c[n] = v[ProtWidth-1:0];
                n++;
            end
        end
        return c;
    endfunction

    localparam col_arr_t Cols = gen_cols();

    logic [ProtWidth-1:0] syn;
    logic                 hit;

    always_comb begin
        syn = in_i[DataWidth +: ProtWidth];
        for (int unsigned j = 0; j < DataWidth; j++) begin
            if (in_i[j]) syn = syn ^ Cols[j];
        end
        out_o = in_i[DataWidth-1:0];
        // weight-1 syndrome is a flipped check bit: data already good
        hit = ($countones(syn) == 1);
        for (int unsigned j = 0; j < DataWidth; j++) begin
            if (syn == Cols[j]) begin
                out_o[j] = ~out_o[j];
                hit      = 1'b1;
            end
        end
        err_o = 2'b00;
        if (syn != '0) err_o = hit ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/relobi_r_other_dec_pipe.sv
// relOBI R "other" field Hsiao decode with optional output register.
// Error counters only exist with RELOBI_R_OTHER_ERR_CNT_EN defined.
module relobi_r_other_dec_pipe
    import relobi_pkg::*;
    import relobi_r_other_dec_pipe_pkg::*;
#(
    parameter  obi_pkg::obi_cfg_t Cfg          = obi_pkg::ObiDefaultConfig,
    parameter  type               r_optional_t = logic,
    parameter  int unsigned       NumChannels  = 1,
    parameter  bit                Registered   = 1'b1,
    parameter  bit                ErrOnUncorr  = 1'b1,
    parameter  int unsigned       CntWidth     = 16,
    parameter  int unsigned       OtherEccWidth = relobi_r_other_ecc_width(Cfg),
    localparam int unsigned       IdW          = Cfg.IdWidth
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     valid_i,
    output logic                                     ready_o,
    input  logic [NumChannels-1:0]                   err_i,
    input  logic [NumChannels-1:0][IdW-1:0]          rid_i,
    input  r_optional_t                              r_optional_i [NumChannels],
    input  logic [NumChannels-1:0][OtherEccWidth-1:0] other_ecc_i,
    output logic                                     valid_o,
    input  logic                                     ready_i,
    output logic [NumChannels-1:0]                   err_o,
    output logic [NumChannels-1:0][IdW-1:0]          rid_o,
    output r_optional_t                              r_optional_o [NumChannels],
    output logic [NumChannels-1:0]                   ecc_corr_o,
    output logic [NumChannels-1:0]                   ecc_uncorr_o,
    input  logic                                     cnt_clear_i,
    output logic [CntWidth-1:0]                      corr_cnt_o,
    output logic [CntWidth-1:0]                      uncorr_cnt_o
);

    localparam int unsigned DataW    = relobi_r_other_width(Cfg);
    localparam bit          UseAtop  = Cfg.OptionalCfg.UseAtop;
    localparam int unsigned RUserW   = Cfg.OptionalCfg.RUserWidth;
    localparam int unsigned RChkW    = Cfg.OptionalCfg.RChkWidth;
    localparam bit          HasOpt   = UseAtop || (RUserW > 0) || (RChkW > 0);
    localparam int unsigned RidOff   = DataW - IdW;
    localparam int unsigned ExOff    = RidOff - (UseAtop ? 1 : 0);
    localparam int unsigned RUserOff = ExOff - RUserW;
    localparam int unsigned RChkOff  = RUserOff - RChkW;

    logic [NumChannels-1:0]          err_c;
    logic [NumChannels-1:0]          corr_c;
    logic [NumChannels-1:0]          uncorr_c;
    logic [NumChannels-1:0][IdW-1:0] rid_c;
    r_optional_t                     opt_c [NumChannels];

    for (genvar k = 0; k < NumChannels; k++) begin : g_lane
        logic [DataW-1:0] pack;
        logic [DataW-1:0] dec;
        logic [1:0]       derr;
        r_optional_t      opt_l;

        if (HasOpt) begin : g_opt
            always_comb begin
                pack = '0;
                for (int unsigned b = 0; b < IdW; b++)
                    pack[RidOff + b] = rid_i[k][b];
                if (UseAtop) pack[ExOff] = r_optional_i[k].exokay;
                for (int unsigned b = 0; b < RUserW; b++)
                    pack[RUserOff + b] = r_optional_i[k].ruser[b];
                for (int unsigned b = 0; b < RChkW; b++)
                    pack[RChkOff + b] = r_optional_i[k].rchk[b];
            end

            always_comb begin
                opt_l = '0;
                if (UseAtop) opt_l.exokay = dec[ExOff];
                for (int unsigned b = 0; b < RUserW; b++)
                    opt_l.ruser[b] = dec[RUserOff + b];
                for (int unsigned b = 0; b < RChkW; b++)
                    opt_l.rchk[b] = dec[RChkOff + b];
            end
        end else begin : g_noopt
            logic unused_opt;
            assign unused_opt = ^r_optional_i[k];
            assign pack       = rid_i[k];
            assign opt_l      = '0;
        end

        hsiao_ecc_dec #(
            .DataWidth (DataW),
            .ProtWidth (OtherEccWidth)
        ) u_dec (
            .in_i  ({other_ecc_i[k], pack}),
            .out_o (dec),
            .err_o (derr)
        );

        assign rid_c[k]    = dec[RidOff +: IdW];
        assign opt_c[k]    = opt_l;
        assign corr_c[k]   = derr[CorrBit];
        assign uncorr_c[k] = derr[UncorrBit];
        // err_i is not covered by the code, only widened by ECC failures
        assign err_c[k]    = err_i[k] | (ErrOnUncorr & uncorr_c[k]);
    end

    if (Registered) begin : g_reg
        logic                            valid_q, valid_d;
        logic [NumChannels-1:0]          err_q, err_d;
        logic [NumChannels-1:0]          corr_q, corr_d;
        logic [NumChannels-1:0]          uncorr_q, uncorr_d;
        logic [NumChannels-1:0][IdW-1:0] rid_q, rid_d;
        r_optional_t                     opt_q [NumChannels];
        r_optional_t                     opt_d [NumChannels];

        assign ready_o = !valid_q | ready_i;

        always_comb begin
            valid_d  = valid_q;
            err_d    = err_q;
            corr_d   = corr_q;
            uncorr_d = uncorr_q;
            rid_d    = rid_q;
            opt_d    = opt_q;
            if (ready_o) valid_d = valid_i;
            if (valid_i && ready_o) begin
                err_d    = err_c;
                corr_d   = corr_c;
                uncorr_d = uncorr_c;
                rid_d    = rid_c;
                opt_d    = opt_c;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q  <= 1'b0;
                err_q    <= '0;
                corr_q   <= '0;
                uncorr_q <= '0;
                rid_q    <= '0;
                for (int k = 0; k < NumChannels; k++) opt_q[k] <= '0;
            end else begin
                valid_q  <= valid_d;
                err_q    <= err_d;
                corr_q   <= corr_d;
                uncorr_q <= uncorr_d;
                rid_q    <= rid_d;
                opt_q    <= opt_d;
            end
        end

        assign valid_o      = valid_q;
        assign err_o        = err_q;
        assign ecc_corr_o   = corr_q;
        assign ecc_uncorr_o = uncorr_q;
        assign rid_o        = rid_q;
        assign r_optional_o = opt_q;
    end else begin : g_comb
        logic unused_clk;
        assign unused_clk   = clk_i ^ rst_ni;
        assign ready_o      = ready_i;
        assign valid_o      = valid_i;
        assign err_o        = err_c;
        assign ecc_corr_o   = corr_c;
        assign ecc_uncorr_o = uncorr_c;
        assign rid_o        = rid_c;
        assign r_optional_o = opt_c;
    end

`ifdef RELOBI_R_OTHER_ERR_CNT_EN
    localparam int unsigned CntW1 = CntWidth + 1;

    logic                accept;
    logic [CntWidth-1:0] corr_cnt_q, corr_cnt_d;
    logic [CntWidth-1:0] uncorr_cnt_q, uncorr_cnt_d;
    logic [CntWidth:0]   corr_sum, uncorr_sum;

    assign accept = valid_i & ready_o;

    always_comb begin
        corr_sum     = {1'b0, corr_cnt_q} + CntW1'($countones(corr_c));
        uncorr_sum   = {1'b0, uncorr_cnt_q} + CntW1'($countones(uncorr_c));
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (accept) begin
            corr_cnt_d   = corr_sum[CntWidth] ? '1 : corr_sum[CntWidth-1:0];
            uncorr_cnt_d = uncorr_sum[CntWidth] ? '1 : uncorr_sum[CntWidth-1:0];
        end
        if (cnt_clear_i) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign corr_cnt_o   = corr_cnt_q;
    assign uncorr_cnt_o = uncorr_cnt_q;
`else
    logic unused_clr;
    assign unused_clr   = cnt_clear_i;
    assign corr_cnt_o   = '0;
    assign uncorr_cnt_o = '0;
`endif

endmodule
